avalon_msg_arbiter: RTL and testbench
=====================================

# avalon_msg_arbiter

Message-level round-robin arbiter that shares one Avalon-ST output among NUM_INPUTS Avalon-ST inputs, normally fed by avalon_enforcer instances. A grant is taken on a valid SOP beat and held until the matching EOP beat transfers, so messages never interleave on the output. Data path is zero-latency: the granted input is muxed combinationally to the output. Only the grant state and round-robin pointer are registered.

## Interface
- DATA_WIDTH_IN_BYTES, 16, bytes per beat; data is DATA_WIDTH_IN_BYTES*8 bits, empty is log2(DATA_WIDTH_IN_BYTES) bits.
- NUM_INPUTS, 4, number of requesting streams, 2..16.
- G_RST_POLARITY, 0, reset active level; fixed at 0 for this block.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- in_msg[NUM_INPUTS]  avalon_st_if.slave  –  requesting streams (data, valid, rdy, sop, eop, empty).
- out_msg  avalon_st_if.master  –  arbitrated stream.
- grant_idx  out  $clog2(NUM_INPUTS)  index of the current or last granted input.
- busy  out  1  1 while the arbiter is locked inside a message (LOCKED state).

## Operation
- Transfer means valid & rdy on the same beat.
- Registered state: state ∈ {IDLE, LOCKED}, lock_idx, rr_ptr (last granted index).
- Eligible input in IDLE: in_msg[i].valid & in_msg[i].sop.
- IDLE selection is combinational. The selected input is the first eligible index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_INPUTS.
- IDLE with a selection:
  - The selected input's data, valid, sop, eop and empty are driven to out_msg.
  - in_msg[sel].rdy = out_msg.rdy.
- IDLE with no eligible input:
  - out_msg.valid, sop, eop, empty and data are all 0.
  - All in_msg rdy are 0.
- An IDLE input asserting valid without sop is never selected and sees rdy = 0. It stalls until it presents a sop.
- LOCKED: out_msg mirrors in_msg[lock_idx] as-is. Only in_msg[lock_idx].rdy = out_msg.rdy.
- Non-granted inputs always see rdy = 0.
- State transitions:
  - IDLE → LOCKED on transfer of a sop beat with eop = 0. lock_idx ← sel, rr_ptr ← sel.
  - IDLE stays IDLE on transfer of a sop & eop single-beat message. rr_ptr ← sel.
  - LOCKED → IDLE on transfer of an eop beat from lock_idx.
  - LOCKED with valid = 0 or rdy = 0 holds state. Bubbles and backpressure do not release the grant.
- A sop appearing mid-message on lock_idx is passed through unchanged. Upstream enforcement is responsible for this case.
- grant_idx = sel in IDLE when a selection exists, lock_idx in LOCKED, otherwise rr_ptr.

## Timing
- Output latency from in_msg to out_msg is 0 cycles (combinational). out_msg.rdy to in_msg.rdy is also 0 cycles.
- Reset values: state = IDLE, rr_ptr = NUM_INPUTS-1 (input 0 has first priority), lock_idx = 0.
  - busy = 0 and grant_idx = NUM_INPUTS-1.
  - With no inputs valid during and after reset, all out_msg fields are 0.
- Grant decision is recomputed every IDLE cycle. A selection that is not accepted (out_msg.rdy = 0) may change next cycle if a higher-priority input becomes eligible.
- After a message ends (eop transfer in cycle n), the next message may start at cycle n+1. The back-to-back rate is 1 beat per cycle with no dead cycle.
- After an eop from input k, priority order is k+1 … k-1, k. Input k is lowest priority next.
- Reset asserted mid-message: immediate return to IDLE and rr_ptr = NUM_INPUTS-1. The partial message is truncated on the output; no eop is generated.
- busy is a registered output: it rises in the cycle after the sop transfer and falls in the cycle after the eop transfer.

## Test plan
- Reset release, inputs 0 and 2 both valid+sop, out rdy = 1 → input 0 granted first.
  - grant_idx = 0, in_msg[2].rdy = 0.
  - After input 0's eop, input 2 is granted on the next cycle with no gap.
- All 4 inputs send continuous 3-beat messages, out rdy = 1 → output message order is 0,1,2,3,0,… and no beats interleave.
- Input 1 sends a 4-beat message with out_msg.rdy toggling 1,0,1,0 and a valid bubble at beat 2; input 3 is waiting → grant stays on 1 (busy = 1) until its eop transfers, then switches to 3.
- Single-beat messages (sop = eop = 1, empty = 5) on inputs 0 and 1 → busy stays 0, empty = 5 passes through, and grants alternate 0,1 on consecutive cycles.
- Input 2 valid with sop = 0 in IDLE while input 3 has a sop → input 3 granted; in_msg[2].rdy = 0 throughout.
- rst driven low during beat 2 of a 5-beat message from input 1 → busy = 0 and out_msg.valid = 0 immediately. After release, input 0 wins over input 1 when both present a sop.

Source files
------------

// File: rtl/avalon_msg_arbiter_if.sv
// rtl/avalon_msg_arbiter_if.sv - Avalon-ST stream interface used by the message arbiter
// Purpose: one Avalon-ST beat bundle with handshake.
// Signals: data, valid, sop, eop, empty (source to sink), rdy (sink to source).
// Modports: master drives a stream, slave receives one.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_msg_arbiter.sv
// rtl/avalon_msg_arbiter.sv - message-level round-robin arbiter for Avalon-ST streams
// Purpose: shares out_msg among NUM_INPUTS streams; a grant is taken on a sop
// beat and held until that input's eop transfers. Data path is combinational.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_msg[]   requesting streams (slave modport)
//   out_msg    arbitrated stream (master modport)
//   grant_idx  current selection, locked input, or last granted input
//   busy       high while locked inside a message
module avalon_msg_arbiter #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int NUM_INPUTS          = 4,
  parameter int G_RST_POLARITY      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  avalon_st_if.slave                    in_msg [NUM_INPUTS],
  avalon_st_if.master                   out_msg,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                          busy
);
  localparam int   DW         = DATA_WIDTH_IN_BYTES * 8;
  localparam int   EW         = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int   IW         = $clog2(NUM_INPUTS);
  localparam logic RST_ACTIVE = (G_RST_POLARITY != 0);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [IW-1:0]         lock_idx;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         sel;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         cur_idx;
  logic                  sel_found;
  logic                  active;
  logic                  xfer;

  logic [DW-1:0]         in_data  [NUM_INPUTS];
  logic [EW-1:0]         in_empty [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS-1:0] in_sop;
  logic [NUM_INPUTS-1:0] in_eop;
  logic [NUM_INPUTS-1:0] in_rdy;

  // Flatten the interface array so the selection index can be variable.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_port
    assign in_data[i]     = in_msg[i].data;
    assign in_empty[i]    = in_msg[i].empty;
    assign in_valid[i]    = in_msg[i].valid;
    assign in_sop[i]      = in_msg[i].sop;
    assign in_eop[i]      = in_msg[i].eop;
    assign in_rdy[i]      = active && (cur_idx == IW'(i)) && out_msg.rdy;
    assign in_msg[i].rdy  = in_rdy[i];
  end

  // Round-robin scan starting just after the last granted input; only a
  // valid sop beat can open a message.
  always_comb begin
    sel_found = 1'b0;
    sel       = rr_ptr;
    cand      = rr_ptr;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_INPUTS);
      if (!sel_found && in_valid[cand] && in_sop[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  assign cur_idx   = (state == LOCKED) ? lock_idx : sel;
  assign active    = (state == LOCKED) || sel_found;
  assign xfer      = active && in_valid[cur_idx] && out_msg.rdy;
  assign grant_idx = cur_idx;
  assign busy      = (state == LOCKED);

  always_comb begin
    out_msg.data  = '0;
    out_msg.valid = 1'b0;
    out_msg.sop   = 1'b0;
    out_msg.eop   = 1'b0;
    out_msg.empty = '0;
    if (active) begin
      out_msg.data  = in_data[cur_idx];
      out_msg.valid = in_valid[cur_idx];
      out_msg.sop   = in_sop[cur_idx];
      out_msg.eop   = in_eop[cur_idx];
      out_msg.empty = in_empty[cur_idx];
    end
  end

  // Bubbles and backpressure inside a message keep the lock; only the
  // transferred eop of the locked input releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= IW'(NUM_INPUTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            rr_ptr <= sel;
            if (!in_eop[sel]) begin
              state    <= LOCKED;
              lock_idx <= sel;
            end
          end
        end
        LOCKED: begin
          if (xfer && in_eop[lock_idx]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_msg_arbiter.sv
// tb/tb_avalon_msg_arbiter.sv - scoreboard bench for avalon_msg_arbiter
module tb_avalon_msg_arbiter;
  localparam int NB = 16;
  localparam int N  = 4;
  localparam int DW = NB * 8;
  localparam int EW = 4;
  localparam int BW = DW + EW + 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [15:0]   gap;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_rdy;
  logic [1:0] grant_idx;
  logic       busy;

  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) in_msg [N] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) out_msg ();

  avalon_msg_arbiter #(
    .DATA_WIDTH_IN_BYTES(NB),
    .NUM_INPUTS(N),
    .G_RST_POLARITY(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_msg(in_msg),
    .out_msg(out_msg),
    .grant_idx(grant_idx),
    .busy(busy)
  );

  assign out_msg.rdy = o_rdy;

  beat_t         drv_q [N][$];
  logic [BW-1:0] exp_q [$];
  wire  [N-1:0]  i_rdy;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            first_cyc = -1;
  int            last_cyc = -1;
  int            msg_id = 0;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // One driver per input: presents queued beats, advances on a transfer.
  for (genvar i = 0; i < N; i++) begin : g_drv
    logic [DW-1:0] d;
    logic          v, s, e;
    logic [EW-1:0] em;
    assign in_msg[i].data  = d;
    assign in_msg[i].valid = v;
    assign in_msg[i].sop   = s;
    assign in_msg[i].eop   = e;
    assign in_msg[i].empty = em;
    assign i_rdy[i]        = in_msg[i].rdy;

    initial begin : drv
      beat_t b;
      bit    have;
      bit    xfer;
      int    gap;
      b = '0; have = 0; xfer = 0; gap = 0;
      d = '0; v = 0; s = 0; e = 0; em = '0;
      forever begin
        @(negedge clk);
        xfer = rst && v && i_rdy[i];
        @(posedge clk);
        #1;
        if (!rst) begin
          have = 0;
        end else begin
          if (have && xfer) have = 0;
          if (!have && drv_q[i].size() > 0) begin
            b = drv_q[i].pop_front();
            have = 1;
            gap = int'(b.gap);
          end
        end
        if (have && gap == 0) begin
          d = b.data; v = 1; s = b.sop; e = b.eop; em = b.empty;
        end else begin
          if (have) gap--;
          d = '0; v = 0; s = 0; e = 0; em = '0;
        end
      end
    end
  end

  // Scoreboard: every output transfer must match the next expected beat.
  always @(negedge clk) begin
    if (rst && out_msg.valid && out_msg.rdy) begin
      if (exp_q.size() == 0)
        check_eq("unexpected_beat", exp_q.size(), 1);
      else
        check_eq("out_beat", {out_msg.data, out_msg.sop, out_msg.eop, out_msg.empty}, exp_q.pop_front());
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  task automatic send_msg(input int port, input int nbeats, input int emp, input int gap_beat, input int exp_beats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data  = {$urandom, $urandom, $urandom, 8'(port), 8'(msg_id), 16'(k)};
      b.sop   = (k == 0);
      b.eop   = (k == nbeats - 1);
      b.empty = b.eop ? EW'(emp) : '0;
      b.gap   = (k == gap_beat) ? 16'd1 : 16'd0;
      drv_q[port].push_back(b);
      if (k < exp_beats) exp_q.push_back({b.data, b.sop, b.eop, b.empty});
    end
    msg_id++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 0;
    for (int p = 0; p < N; p++) drv_q[p].delete();
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst   = 0;
    o_rdy = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant_idx, 3);
    check_eq("rst_valid", out_msg.valid, 0);
    check_eq("rst_fields", {out_msg.data, out_msg.sop, out_msg.eop, out_msg.empty}, 0);
    check_eq("rst_rdy", i_rdy, 0);
    @(posedge clk);
    #3;
    rst = 1;

    // Inputs 0 and 2 compete; 0 first, then 2 with no gap
    send_msg(0, 3, 0, -1, 3);
    send_msg(2, 2, 3, -1, 2);
    first_cyc = -1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check_eq("t1_grant", grant_idx, 0);
    check_eq("t1_rdy2", i_rdy[2], 0);
    check_eq("t1_rdy0", i_rdy[0], 1);
    wait_drain("t1_drain", 50);
    check_eq("t1_span", last_cyc - first_cyc + 1, 5);

    // All inputs, continuous 3-beat messages: order 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) send_msg(p, 3, p, -1, 3);
    first_cyc = -1;
    wait_drain("t2_drain", 100);
    check_eq("t2_span", last_cyc - first_cyc + 1, 24);
    repeat (2) @(posedge clk);

    // Input 1 locked through backpressure and a bubble; input 3 waits
    send_msg(1, 4, 0, 2, 4);
    send_msg(3, 2, 7, -1, 2);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      o_rdy = (n % 2 == 0);
      n++;
      @(negedge clk);
      #1;
      if (exp_q.size() >= 3 && exp_q.size() <= 4) begin
        check_eq("t3_busy", busy, 1);
        check_eq("t3_grant", grant_idx, 1);
        check_eq("t3_rdy3", i_rdy[3], 0);
      end
    end
    wait_drain("t3_drain", 10);
    @(posedge clk);
    #1;
    o_rdy = 1;
    repeat (2) @(posedge clk);

    // Single-beat messages on 0 and 1 alternate with busy low
    send_msg(0, 1, 5, -1, 1);
    send_msg(1, 1, 5, -1, 1);
    send_msg(0, 1, 5, -1, 1);
    send_msg(1, 1, 5, -1, 1);
    first_cyc = -1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
      check_eq("t4_busy", busy, 0);
    end
    wait_drain("t4_drain", 10);
    check_eq("t4_span", last_cyc - first_cyc + 1, 4);
    repeat (2) @(posedge clk);

    // Input 2 valid without sop is never granted; input 3 goes through
    begin
      beat_t b;
      b = '0;
      b.data = {$urandom, $urandom, $urandom, 32'h0200_FFFF};
      b.eop = 1;
      drv_q[2].push_back(b);
    end
    send_msg(3, 2, 0, -1, 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check_eq("t5_grant", grant_idx, 3);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      check_eq("t5_rdy2", i_rdy[2], 0);
      @(negedge clk);
      #1;
      n++;
    end
    wait_drain("t5_drain", 10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t5_idle_rdy2", i_rdy[2], 0);
    check_eq("t5_idle_valid", out_msg.valid, 0);

    // Reset mid-message truncates; input 0 wins afterwards
    do_reset();
    send_msg(1, 5, 0, -1, 2);
    wait_drain("t6_pre_drain", 20);
    @(posedge clk);
    #3;
    check_eq("t6_busy_before", busy, 1);
    rst = 0;
    drv_q[1].delete();
    #1;
    check_eq("t6_busy_rst", busy, 0);
    check_eq("t6_valid_rst", out_msg.valid, 0);
    send_msg(0, 2, 0, -1, 2);
    send_msg(1, 2, 0, -1, 2);
    repeat (2) @(posedge clk);
    #3;
    rst = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check_eq("t6_grant", grant_idx, 0);
    check_eq("t6_rdy1", i_rdy[1], 0);
    wait_drain("t6_drain", 20);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
